// File: rtl/bandit_arbiter.sv
// Round-robin share of one bandit core: grant a client, pass one action to it, return its reward.
// Latency: one IDLE arbitration cycle, then ACTION and REWARD are combinational pass-through (3 cycles minimum).
// Backpressure: valid/ready forwarded only to/from the granted client; optional reward timeout via BANDIT_ARB_TIMEOUT_EN.
module bandit_arbiter #(
    parameter int                 NUM_CLIENTS    = 4,
    parameter int                 ID_WIDTH       = 2,
    parameter int                 TIMEOUT        = 1024,
    parameter logic signed [15:0] DEFAULT_REWARD = 16'sh0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    client_req,
    output logic [NUM_CLIENTS-1:0]    client_action_valid,
    output logic [7:0]                client_action_data,
    input  logic [NUM_CLIENTS-1:0]    client_action_ready,
    input  logic [NUM_CLIENTS-1:0]    client_reward_valid,
    input  logic [16*NUM_CLIENTS-1:0] client_reward_data,
    output logic [NUM_CLIENTS-1:0]    client_reward_ready,
    input  logic                      core_action_valid,
    input  logic [7:0]                core_action_data,
    output logic                      core_action_ready,
    output logic                      core_reward_valid,
    output logic signed [15:0]        core_reward_data,
    input  logic                      core_reward_ready,
    output logic [ID_WIDTH-1:0]       grant_id,
    output logic                      busy,
    output logic                      timeout
);

    typedef enum logic [1:0] {IDLE, ACTION, REWARD} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] last_q, last_d;
    logic [ID_WIDTH-1:0] pick;
    logic                pick_vld;
    logic signed [15:0]  rew [NUM_CLIENTS];
    logic                expired;

    assign client_action_data = core_action_data;
    assign grant_id           = grant_q;
    assign busy               = (state_q != IDLE);

    // Unpack the flat reward bus so the granted client can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rew[i] = client_reward_data[16*i +: 16];
        end
    end

    // Round-robin search: first requester at or after last+1, wrapping around.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = ID_WIDTH'((int'(last_q) + k) % NUM_CLIENTS);
            if (!pick_vld && client_req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

`ifdef BANDIT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A client reward arriving on the expiry cycle still wins over the default.
    assign expired = (cnt_q == CNT_W'(TIMEOUT)) && !client_reward_valid[grant_q];

    // Wait counter: cleared while in ACTION (i.e. on REWARD entry), saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ACTION) begin
            cnt_d = '0;
        end else if (state_q == REWARD && !client_reward_valid[grant_q] &&
                     cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign expired            = 1'b0;
`endif

    // Handshake steering: every valid/ready is decoded from the state and the held grant.
    always_comb begin
        client_action_valid = '0;
        client_reward_ready = '0;
        core_action_ready   = 1'b0;
        core_reward_valid   = 1'b0;
        core_reward_data    = '0;
        timeout             = 1'b0;
        case (state_q)
            ACTION: begin
                client_action_valid[grant_q] = core_action_valid;
                core_action_ready            = client_action_ready[grant_q];
            end
            REWARD: begin
                if (expired) begin
                    core_reward_valid = 1'b1;
                    core_reward_data  = DEFAULT_REWARD;
                    timeout           = core_reward_ready;
                end else begin
                    core_reward_valid            = client_reward_valid[grant_q];
                    core_reward_data             = rew[grant_q];
                    client_reward_ready[grant_q] = core_reward_ready;
                end
            end
            default: ;
        endcase
    end

    // Next state: arbitrate in IDLE, hold grant until the reward transfer completes.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = ACTION;
                end
            end
            ACTION: begin
                if (core_action_valid && client_action_ready[grant_q]) state_d = REWARD;
            end
            REWARD: begin
                if (core_reward_valid && core_reward_ready) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last starts at the top client so client 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(NUM_CLIENTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
